// File: rtl/pong_pkg.sv
// Shared Pong definitions: playfield defaults, difficulty codes and the
// computer-opponent FSM state type.
// Ports: none (package).
package pong_pkg;

  // Playfield defaults shared by the player paddle, AI paddle and renderer.
  localparam int unsigned Y_MAX_DEFAULT    = 480;
  localparam int unsigned PADDLE_H_DEFAULT = 64;

  // Width of the tick / reaction counters; wide enough for the largest
  // reaction delay (6,000,000 cycles).
  localparam int unsigned CNT_W = 24;

  typedef logic [1:0] diff_t;

  localparam diff_t DIFF_OFF  = 2'b00;
  localparam diff_t DIFF_EASY = 2'b01;
  localparam diff_t DIFF_MED  = 2'b10;
  localparam diff_t DIFF_HARD = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REACT    = 2'd1,
    TRACK    = 2'd2,
    RECENTER = 2'd3
  } ai_state_t;

endpackage

// File: rtl/ai_rate_table.sv
// Difficulty lookup for the AI paddle: maps diff to the number of clock
// cycles per 1 px step and the reaction delay applied before tracking.
// Ports:
//   diff          in   difficulty code (00 = off, 01 easy, 10 med, 11 hard)
//   ticks_per_px  out  cycles per pixel step
//   react_cycles  out  reaction delay in cycles
module ai_rate_table
  import pong_pkg::*;
#(
  parameter int unsigned TICKS_EASY = 80000,
  parameter int unsigned TICKS_MED  = 40000,
  parameter int unsigned TICKS_HARD = 20000,
  parameter int unsigned REACT_EASY = 6000000,
  parameter int unsigned REACT_MED  = 3000000,
  parameter int unsigned REACT_HARD = 0
) (
  input  diff_t            diff,
  output logic [CNT_W-1:0] ticks_per_px,
  output logic [CNT_W-1:0] react_cycles
);

  // Select the rate pair for the current difficulty.
  always_comb begin
    ticks_per_px = CNT_W'(TICKS_EASY);
    react_cycles = CNT_W'(REACT_EASY);
    case (diff)
      DIFF_EASY: begin
        ticks_per_px = CNT_W'(TICKS_EASY);
        react_cycles = CNT_W'(REACT_EASY);
      end
      DIFF_MED: begin
        ticks_per_px = CNT_W'(TICKS_MED);
        react_cycles = CNT_W'(REACT_MED);
      end
      DIFF_HARD: begin
        ticks_per_px = CNT_W'(TICKS_HARD);
        react_cycles = CNT_W'(REACT_HARD);
      end
      default: begin
        // AI off: the paddle is frozen, so the values are never used.
        ticks_per_px = CNT_W'(TICKS_EASY);
        react_cycles = CNT_W'(REACT_EASY);
      end
    endcase
  end

endmodule

// File: rtl/ai_paddle_tracker.sv
// Computer opponent for Pong. Owns the paddle position, follows the ball at
// a per-difficulty speed after a reaction delay, ignores small errors
// (dead-zone) and drifts back to the centre while the ball travels away.
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous active-low reset
//   game_on      in   1 = play running, 0 = freeze
//   diff         in   difficulty (00 off/hold, 01 easy, 10 med, 11 hard)
//   ball_y       in   ball centre y in px (y grows downward)
//   ball_toward  in   1 = ball travelling toward this paddle
//   position     out  paddle top edge y in px
//   moving_up    out  last evaluation stepped the paddle up
//   moving_down  out  last evaluation stepped the paddle down
module ai_paddle_tracker
  import pong_pkg::*;
#(
  parameter int unsigned Y_MAX      = Y_MAX_DEFAULT,
  parameter int unsigned PADDLE_H   = PADDLE_H_DEFAULT,
  parameter int unsigned POS_W      = 10,
  parameter int unsigned DEADZONE   = 4,
  parameter int unsigned TICKS_EASY = 80000,
  parameter int unsigned TICKS_MED  = 40000,
  parameter int unsigned TICKS_HARD = 20000,
  parameter int unsigned REACT_EASY = 6000000,
  parameter int unsigned REACT_MED  = 3000000,
  parameter int unsigned REACT_HARD = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             game_on,
  input  diff_t            diff,
  input  logic [POS_W-1:0] ball_y,
  input  logic             ball_toward,
  output logic [POS_W-1:0] position,
  output logic             moving_up,
  output logic             moving_down
);

  // Two extra bits: one for sign, one so ball_y minus paddle centre never
  // overflows.
  localparam int unsigned ERR_W = POS_W + 2;

  localparam logic [POS_W-1:0] CENTER_POS = POS_W'((Y_MAX - PADDLE_H) / 2);
  localparam logic [POS_W-1:0] PMAX_POS   = POS_W'(Y_MAX - PADDLE_H);
  localparam logic [POS_W-1:0] POS_ZERO   = POS_W'(0);
  localparam logic [POS_W-1:0] POS_ONE    = POS_W'(1);
  localparam logic [ERR_W-1:0] HALF_H     = ERR_W'(PADDLE_H / 2);
  localparam logic signed [ERR_W-1:0] DZ_POS = ERR_W'(DEADZONE);
  localparam logic signed [ERR_W-1:0] DZ_NEG = -(ERR_W'(DEADZONE));
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] ticks_per_px;
  logic [CNT_W-1:0] react_cycles;

  ai_rate_table #(
    .TICKS_EASY (TICKS_EASY),
    .TICKS_MED  (TICKS_MED),
    .TICKS_HARD (TICKS_HARD),
    .REACT_EASY (REACT_EASY),
    .REACT_MED  (REACT_MED),
    .REACT_HARD (REACT_HARD)
  ) u_rate_table (
    .diff         (diff),
    .ticks_per_px (ticks_per_px),
    .react_cycles (react_cycles)
  );

  ai_state_t        state_q, state_d;
  logic [CNT_W-1:0] tick_q, tick_d;
  logic [CNT_W-1:0] react_q, react_d;
  logic [POS_W-1:0] position_q, position_d;
  logic             moving_up_q, moving_up_d;
  logic             moving_down_q, moving_down_d;
  diff_t            diff_prev_q, diff_prev_d;

  logic                    run_ok;
  logic [ERR_W-1:0]        paddle_mid;
  logic signed [ERR_W-1:0] err;
  logic                    want_up, want_down;
  logic                    step_up, step_down;

  assign run_ok = game_on && (diff != DIFF_OFF);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; game_on=0 or AI off overrides everything.
  always_comb begin
    state_d = state_q;
    if (!run_ok) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (ball_toward) state_d = REACT;
          else             state_d = RECENTER;
        end
        REACT: begin
          if (react_q == CNT_ZERO) state_d = TRACK;
          else                     state_d = REACT;
        end
        TRACK: begin
          if (!ball_toward) state_d = RECENTER;
          else              state_d = TRACK;
        end
        RECENTER: begin
          if (ball_toward) state_d = REACT;
          else             state_d = RECENTER;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Tracking error against the paddle centre, plus the wanted direction
  // for the current state.
  always_comb begin
    paddle_mid = {2'b00, position_q} + HALF_H;
    err        = $signed({2'b00, ball_y}) - $signed(paddle_mid);
    want_up    = 1'b0;
    want_down  = 1'b0;
    if (state_q == TRACK) begin
      want_down = (err > DZ_POS);
      want_up   = (err < DZ_NEG);
    end else if (state_q == RECENTER) begin
      want_down = (position_q < CENTER_POS);
      want_up   = (position_q > CENTER_POS);
    end else begin
      want_up   = 1'b0;
      want_down = 1'b0;
    end
    // Clamp: a step that would leave [0, PMAX] is dropped, never wrapped.
    step_down = want_down && (position_q < PMAX_POS);
    step_up   = want_up && (position_q > POS_ZERO);
  end

  // Datapath next values: reaction counter, tick counter, position, flags.
  always_comb begin
    diff_prev_d   = diff;
    react_d       = react_q;
    tick_d        = tick_q;
    position_d    = position_q;
    moving_up_d   = moving_up_q;
    moving_down_d = moving_down_q;

    // Reaction delay is re-armed on every entry into REACT.
    if ((state_d == REACT) && (state_q != REACT)) begin
      react_d = react_cycles;
    end else if ((state_q == REACT) && (react_q != CNT_ZERO)) begin
      react_d = react_q - CNT_ONE;
    end else begin
      react_d = react_q;
    end

    if (!run_ok || ((state_q != TRACK) && (state_q != RECENTER))) begin
      tick_d        = CNT_ZERO;
      moving_up_d   = 1'b0;
      moving_down_d = 1'b0;
    end else if (diff != diff_prev_q) begin
      // Restart the step period so the new rate starts from a clean count.
      tick_d = CNT_ZERO;
    end else if ((tick_q + CNT_ONE) >= ticks_per_px) begin
      // Terminal count: evaluate once and step at most 1 px.
      tick_d        = CNT_ZERO;
      moving_up_d   = step_up;
      moving_down_d = step_down;
      if (step_down) begin
        position_d = position_q + POS_ONE;
      end else if (step_up) begin
        position_d = position_q - POS_ONE;
      end else begin
        position_d = position_q;
      end
    end else begin
      tick_d = tick_q + CNT_ONE;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_q        <= CNT_ZERO;
      react_q       <= CNT_ZERO;
      position_q    <= CENTER_POS;
      moving_up_q   <= 1'b0;
      moving_down_q <= 1'b0;
      diff_prev_q   <= DIFF_OFF;
    end else begin
      tick_q        <= tick_d;
      react_q       <= react_d;
      position_q    <= position_d;
      moving_up_q   <= moving_up_d;
      moving_down_q <= moving_down_d;
      diff_prev_q   <= diff_prev_d;
    end
  end

  assign position    = position_q;
  assign moving_up   = moving_up_q;
  assign moving_down = moving_down_q;

endmodule

// File: tb/tb_ai_paddle_tracker.sv
// Directed bench for ai_paddle_tracker with a small rate table
// (TICKS 4/2/1, REACT 8/4/0). Outputs are sampled on the falling edge.
module tb_ai_paddle_tracker;

  logic       clk = 1'b0;
  logic       reset;
  logic       game_on;
  logic [1:0] diff;
  logic [9:0] ball_y;
  logic       ball_toward;
  logic [9:0] position;
  logic       moving_up;
  logic       moving_down;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ai_paddle_tracker #(
    .Y_MAX      (480),
    .PADDLE_H   (64),
    .POS_W      (10),
    .DEADZONE   (4),
    .TICKS_EASY (4),
    .TICKS_MED  (2),
    .TICKS_HARD (1),
    .REACT_EASY (8),
    .REACT_MED  (4),
    .REACT_HARD (0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .game_on     (game_on),
    .diff        (diff),
    .ball_y      (ball_y),
    .ball_toward (ball_toward),
    .position    (position),
    .moving_up   (moving_up),
    .moving_down (moving_down)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_state(input string tag, input int pos, input logic up, input logic dn);
    check({tag, "_pos"}, 32'(position), 32'(pos));
    check({tag, "_up"}, 32'(moving_up), 32'(up));
    check({tag, "_dn"}, 32'(moving_down), 32'(dn));
  endtask

  initial begin
    reset       = 1'b0;
    game_on     = 1'b1;
    diff        = 2'b11;
    ball_toward = 1'b1;
    ball_y      = 10'd400;

    // Reset value.
    cyc(2);
    check_state("reset", 208, 1'b0, 1'b0);
    reset = 1'b1;

    // Hard tracking toward ball_y=400: IDLE, REACT(0), then 1 px per cycle.
    cyc(1);
    check_state("hard_wait", 208, 1'b0, 1'b0);
    cyc(2);
    check_state("hard_first", 209, 1'b0, 1'b1);
    cyc(10);
    check_state("hard_run", 219, 1'b0, 1'b1);
    // Stops where err reaches the dead-zone edge: 400 - (364 + 32) = 4.
    cyc(187);
    check_state("hard_stop", 364, 1'b0, 1'b0);

    // Ball moves away: recentre toward 208.
    ball_toward = 1'b0;
    cyc(10);
    check_state("recenter_run", 355, 1'b1, 1'b0);
    cyc(190);
    check_state("recenter_hold", 208, 1'b0, 1'b0);

    // Dead-zone: centre 240, ball at 243 -> hold; 245 -> one step down.
    ball_y      = 10'd243;
    ball_toward = 1'b1;
    cyc(10);
    check_state("dz_hold", 208, 1'b0, 1'b0);
    ball_y = 10'd245;
    cyc(1);
    check_state("dz_step", 209, 1'b0, 1'b1);
    cyc(1);
    check_state("dz_settle", 209, 1'b0, 1'b0);

    // Clamp at the top and bottom, including ball_y beyond the field.
    ball_y = 10'd0;
    cyc(300);
    check_state("clamp_top", 0, 1'b0, 1'b0);
    ball_y = 10'd479;
    cyc(500);
    check_state("clamp_bot", 416, 1'b0, 1'b0);
    ball_y = 10'd1000;
    cyc(5);
    check_state("clamp_far", 416, 1'b0, 1'b0);

    // Easy: away for one cycle, then toward -> 9 cycles in REACT, then
    // 1 px every 4 cycles upward.
    diff        = 2'b01;
    ball_y      = 10'd100;
    ball_toward = 1'b0;
    cyc(1);
    check_state("easy_pre", 416, 1'b0, 1'b0);
    ball_toward = 1'b1;
    cyc(9);
    check_state("easy_react", 416, 1'b0, 1'b0);
    cyc(4);
    check_state("easy_before", 416, 1'b0, 1'b0);
    cyc(1);
    check_state("easy_step1", 415, 1'b1, 1'b0);
    cyc(3);
    check_state("easy_gap", 415, 1'b1, 1'b0);
    cyc(1);
    check_state("easy_step2", 414, 1'b1, 1'b0);

    // diff change mid-TRACK: one cleared cycle, then the new spacing.
    diff = 2'b11;
    cyc(1);
    check("to_hard_clr_pos", 32'(position), 32'd414);
    cyc(1);
    check("to_hard_s1_pos", 32'(position), 32'd413);
    cyc(1);
    check("to_hard_s2_pos", 32'(position), 32'd412);
    diff = 2'b01;
    cyc(4);
    check_state("to_easy_gap", 412, 1'b1, 1'b0);
    cyc(1);
    check("to_easy_s1_pos", 32'(position), 32'd411);
    cyc(4);
    check("to_easy_s2_pos", 32'(position), 32'd410);

    // game_on=0 mid-move: frozen, flags cleared, position kept.
    game_on = 1'b0;
    cyc(1);
    check_state("freeze", 410, 1'b0, 1'b0);
    cyc(20);
    check_state("freeze_hold", 410, 1'b0, 1'b0);

    // Resume on hard, run up through 300, then async reset mid-move.
    game_on = 1'b1;
    diff    = 2'b11;
    cyc(112);
    check_state("resume", 300, 1'b1, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check_state("async_reset", 208, 1'b0, 1'b0);
    cyc(1);
    reset = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
